shift_exec_stage: RTL
=====================

// Module: shift_exec_stage
// PURPOSE
//   Two-stage pipelined shift unit for the RV32 execute stage. Accepts a shift
//   op (SLL/SRL/SRA) from ID/EX with a valid/ready handshake, registers the
//   operands (S1), computes the shift, and registers the result plus rd (S2)
//   toward the writeback/bypass stage. Full throughput of one op per cycle;
//   stalls propagate upstream under downstream backpressure.
// PARAMETERS
//   DATA_W   32                 operand/result width
//   SHAMT_W  $clog2(DATA_W)     shift-amount width (5 for RV32)
//   RD_W     5                  destination register index width
// PORTS
//   i_clk        in   1        clock, rising edge
//   i_rst_n      in   1        asynchronous, active-low reset
//   i_flush      in   1        synchronous pipeline flush (branch/trap)
//   i_valid      in   1        upstream op valid
//   o_ready      out  1        this block can accept an op this cycle
//   i_op         in   2        00=SLL, 01=SRL, 11=SRA, 10=reserved
//   i_rs1_data   in   DATA_W   value to shift
//   i_shamt      in   SHAMT_W  shift amount (rs2[4:0] or imm[4:0])
//   i_rd_addr    in   RD_W     destination register index
//   o_valid      out  1        result valid
//   i_ready      in   1        downstream accepts result
//   o_result     out  DATA_W   shifted result
//   o_rd_addr    out  RD_W     destination register index of o_result
// BEHAVIOUR
// - Reset (i_rst_n low, async): S1/S2 valid = 0; all S1/S2 data regs = 0;
//   so o_valid=0, o_result=0, o_rd_addr=0. Registers released on first edge.
// - Handshake: transfer occurs on a rising edge when valid & ready both high.
//   o_valid/o_result/o_rd_addr stay stable while o_valid && !i_ready.
// - s2_adv = !s2_valid || i_ready; s1_adv = s1_valid && s2_adv.
//   o_ready = !s1_valid || s2_adv (combinational path from i_ready allowed).
// - Accept (i_valid && o_ready): S1 <= {i_op, i_rs1_data, i_shamt, i_rd_addr},
//   s1_valid <= 1. Else if s1_adv: s1_valid <= 0. Else S1 holds.
// - s1_adv: S2 <= {shift(S1), S1.rd}, s2_valid <= 1. Else if i_ready:
//   s2_valid <= 0. Else S2 holds. S1 drain and S1 refill in same edge allowed.
// - Latency: op accepted at edge N -> o_valid high after edge N+1 (2 cycles)
//   when unstalled. Results leave in acceptance order; none dropped/duplicated.
// - Shift arithmetic (S1 -> S2, combinational, shamt = S1.shamt, 0..DATA_W-1):
//   SLL: data << shamt, zero fill. SRL: data >> shamt, zero fill.
//   SRA: data >> shamt, fill with data[DATA_W-1]. 10: result = 0.
//   shamt = 0 -> result = data unchanged for SLL/SRL/SRA.
// - Flush (i_flush high at edge): s1_valid <= 0, s2_valid <= 0; op offered in
//   the flush cycle is discarded even if i_valid && o_ready; flush overrides
//   accept and advance. Data regs may keep stale values; o_valid=0 next cycle.
// - Reset asserted mid-operation: in-flight ops lost, outputs to reset values
//   immediately (async); no partial result is ever presented.
// - No internal state beyond S1/S2; no FSM other than the two valid bits
//   (EMPTY, S1 only, S2 only, BOTH).
// TESTING
//   1. SLL 0x0000_0001, shamt 31, i_ready=1 -> o_valid 2 cycles later,
//      o_result=0x8000_0000, o_rd_addr echoes input.
//   2. SRA 0x8000_0000 shamt 4 -> 0xF800_0000; SRL same -> 0x0800_0000;
//      SLL 0xDEAD_BEEF shamt 0 -> 0xDEAD_BEEF; op 10 -> 0x0000_0000.
//   3. 3 back-to-back ops, i_ready=0 for 4 cycles: 2 accepted, o_ready=0 after
//      both stages full, o_result stable; release -> 3 results in order.
//   4. Continuous i_valid/i_ready=1 for 16 ops, random data/shamt -> one result
//      per cycle, matches reference model, o_ready never drops.
//   5. Both stages full, assert i_flush with i_valid=1 -> next cycle o_valid=0,
//      flushed-cycle op never appears; following op flows with 2-cycle latency.
//   6. Drop i_rst_n with S2 holding a result -> o_valid=0, o_result=0 without
//      a clock edge; after release, o_ready=1 and first op completes normally.

Source files
------------

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage pipelined SLL/SRL/SRA unit with valid/ready flow control.
// S1 registers the operands, S2 registers the shifted result and rd.
module shift_exec_stage #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = $clog2(DATA_W),
    parameter int RD_W    = 5
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [1:0]         i_op,
    input  logic [DATA_W-1:0]  i_rs1_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [RD_W-1:0]    i_rd_addr,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [DATA_W-1:0]  o_result,
    output logic [RD_W-1:0]    o_rd_addr
);
    logic                      s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [1:0]                s1_op_q;
    logic [DATA_W-1:0]         s1_data_q, s2_res_q, shift_res;
    logic signed [DATA_W-1:0]  sra_res;
    logic [SHAMT_W-1:0]        s1_shamt_q;
    logic [RD_W-1:0]           s1_rd_q, s2_rd_q;
    logic                      s2_adv, s1_adv, accept;

    assign s2_adv  = !s2_valid_q || i_ready;
    assign s1_adv  = s1_valid_q && s2_adv;
    assign o_ready = !s1_valid_q || s2_adv;
    assign accept  = i_valid && o_ready && !i_flush;

    // kept as its own signed net so the arithmetic shift is not demoted to logical
    assign sra_res = $signed(s1_data_q) >>> s1_shamt_q;

    always_comb begin
        shift_res  = s1_op_q == 2'b00 ? s1_data_q << s1_shamt_q :
                     s1_op_q == 2'b01 ? s1_data_q >> s1_shamt_q :
                     s1_op_q == 2'b11 ? DATA_W'(sra_res) : '0;
        s1_valid_d = i_flush ? 1'b0 : accept ? 1'b1 : s1_adv ? 1'b0 : s1_valid_q;
        s2_valid_d = i_flush ? 1'b0 : s1_adv ? 1'b1 : i_ready ? 1'b0 : s2_valid_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_data_q  <= '0;
            s1_shamt_q <= '0;
            s1_rd_q    <= '0;
            s2_res_q   <= '0;
            s2_rd_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (accept) begin
                s1_op_q    <= i_op;
                s1_data_q  <= i_rs1_data;
                s1_shamt_q <= i_shamt;
                s1_rd_q    <= i_rd_addr;
            end
            if (s1_adv && !i_flush) begin
                s2_res_q <= shift_res;
                s2_rd_q  <= s1_rd_q;
            end
        end
    end

    assign o_valid   = s2_valid_q;
    assign o_result  = s2_res_q;
    assign o_rd_addr = s2_rd_q;
endmodule
